// File: rtl/definitions.sv
// Shared types for the execute-stage compare path.
// Float32 is a raw IEEE-754 single-precision bit pattern.
// Compare_in is the request bundle launched by the decode/execute register.
package definitions;

    typedef logic [31:0] Float32;
    typedef logic        Signal;

    typedef struct packed {
        logic [1:0] op;   // 0 EQ, 1 LT, 2 LE, 3 UN
        Float32     a;
        Float32     b;
        logic [4:0] dst;  // flag index, 0 means no request
    } Compare_in;

endpackage

// File: rtl/fp_compare_unit.sv
// Two-stage IEEE-754 single-precision compare writing a 32x1 condition-flag file.
// Ports: clk/rst (sync, active-high), stall, cmp_in request, rd_addr -> rd_flag
// (forwarded from S2) and flag_busy (target still in S1, hazard request).
module fp_compare_unit
    import definitions::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  Compare_in  cmp_in,
    input  logic [4:0] rd_addr,
    output logic       rd_flag,
    output logic       flag_busy
);

    // ------------------------------------------------------------------
    // Stage 1 combinational: classification and magnitude compare
    // ------------------------------------------------------------------
    logic a_nan, b_nan, both_zero, mag_lt, mag_gt;
    logic cls_nan, cls_eq, cls_lt;

    always_comb begin
        a_nan     = (&cmp_in.a[30:23]) && (|cmp_in.a[22:0]);
        b_nan     = (&cmp_in.b[30:23]) && (|cmp_in.b[22:0]);
        both_zero = (~|cmp_in.a[30:0]) && (~|cmp_in.b[30:0]);
        mag_lt    = cmp_in.a[30:0] < cmp_in.b[30:0];
        mag_gt    = cmp_in.a[30:0] > cmp_in.b[30:0];
        cls_nan   = a_nan || b_nan;
        // +0 and -0 differ only in sign but must compare equal.
        cls_eq    = both_zero || (cmp_in.a == cmp_in.b);

        if (both_zero) begin
            cls_lt = 1'b0;
        end else if (cmp_in.a[31] != cmp_in.b[31]) begin
            // Signs differ: the negative operand is the smaller one.
            cls_lt = cmp_in.a[31];
        end else if (cmp_in.a[31]) begin
            // Both negative: larger magnitude is the smaller value.
            cls_lt = mag_gt;
        end else begin
            cls_lt = mag_lt;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline and flag-file state
    // ------------------------------------------------------------------
    logic        s1_vld_q, s1_vld_d;
    logic [1:0]  s1_op_q,  s1_op_d;
    logic [4:0]  s1_dst_q, s1_dst_d;
    logic        s1_nan_q, s1_nan_d;
    logic        s1_eq_q,  s1_eq_d;
    logic        s1_lt_q,  s1_lt_d;

    logic        s2_vld_q, s2_vld_d;
    logic [4:0]  s2_dst_q, s2_dst_d;
    logic        s2_res_q, s2_res_d;

    logic [31:0] flags_q,  flags_d;

    logic        op_res;

    // Stage 2 op select: any NaN forces the ordered predicates false.
    always_comb begin
        case (s1_op_q)
            2'd0:    op_res = !s1_nan_q && s1_eq_q;
            2'd1:    op_res = !s1_nan_q && s1_lt_q;
            2'd2:    op_res = !s1_nan_q && (s1_lt_q || s1_eq_q);
            default: op_res = s1_nan_q;
        endcase
    end

    always_comb begin
        // S1 holds under stall; otherwise it takes the new request.
        s1_vld_d = s1_vld_q;
        s1_op_d  = s1_op_q;
        s1_dst_d = s1_dst_q;
        s1_nan_d = s1_nan_q;
        s1_eq_d  = s1_eq_q;
        s1_lt_d  = s1_lt_q;
        if (!stall) begin
            s1_vld_d = (cmp_in.dst != 5'd0);
            s1_op_d  = cmp_in.op;
            s1_dst_d = cmp_in.dst;
            s1_nan_d = cls_nan;
            s1_eq_d  = cls_eq;
            s1_lt_d  = cls_lt;
        end

        // S2 loads a bubble under stall so a held S1 entry is written once.
        s2_vld_d = s1_vld_q && !stall;
        s2_dst_d = s1_dst_q;
        s2_res_d = op_res;

        flags_d = flags_q;
        if (s2_vld_q) begin
            flags_d[s2_dst_q] = s2_res_q;
        end
        flags_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= 2'd0;
            s1_dst_q <= 5'd0;
            s1_nan_q <= 1'b0;
            s1_eq_q  <= 1'b0;
            s1_lt_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_dst_q <= 5'd0;
            s2_res_q <= 1'b0;
            flags_q  <= 32'd0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_op_q  <= s1_op_d;
            s1_dst_q <= s1_dst_d;
            s1_nan_q <= s1_nan_d;
            s1_eq_q  <= s1_eq_d;
            s1_lt_q  <= s1_lt_d;
            s2_vld_q <= s2_vld_d;
            s2_dst_q <= s2_dst_d;
            s2_res_q <= s2_res_d;
            flags_q  <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Read port: flag 0, then S2 forward, then the file
    // ------------------------------------------------------------------
    always_comb begin
        if (rd_addr == 5'd0) begin
            rd_flag = 1'b0;
        end else if (s2_vld_q && (s2_dst_q == rd_addr)) begin
            rd_flag = s2_res_q;
        end else begin
            rd_flag = flags_q[rd_addr];
        end
        flag_busy = s1_vld_q && (s1_dst_q == rd_addr) && (rd_addr != 5'd0);
    end

endmodule

// File: tb/tb_fp_compare_unit.sv
module tb_fp_compare_unit;
    import definitions::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    Compare_in  cmp_in;
    logic [4:0] rd_addr;
    logic       rd_flag;
    logic       flag_busy;

    always #5 clk = ~clk;

    fp_compare_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .cmp_in    (cmp_in),
        .rd_addr   (rd_addr),
        .rd_flag   (rd_flag),
        .flag_busy (flag_busy)
    );

    typedef struct {
        bit flag;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: committed flags plus the requests still in flight,
    // tracked by how many clock edges they have seen since issue.
    bit        m_flags[32];
    bit        m1_vld, m2_vld;
    int        m1_dst, m2_dst;
    bit        m1_res, m2_res;
    bit        p_rst, p_stall;
    Compare_in p_cmp;

    // Map a float onto a signed integer line so that ordinary integer
    // comparison gives IEEE ordering; both zeros land on 0.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'({33'd0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit nan;
        nan = is_nan(a) || is_nan(b);
        if (op == 2'd3) return nan;
        if (nan) return 1'b0;
        case (op)
            2'd0:    return fkey(a) == fkey(b);
            2'd1:    return fkey(a) <  fkey(b);
            default: return fkey(a) <= fkey(b);
        endcase
    endfunction

    task automatic model_clock();
        if (p_rst) begin
            foreach (m_flags[i]) m_flags[i] = 1'b0;
            m1_vld = 1'b0;
            m2_vld = 1'b0;
        end else begin
            if (m2_vld) m_flags[m2_dst] = m2_res;
            if (p_stall) begin
                m2_vld = 1'b0;
            end else begin
                m2_vld = m1_vld;
                m2_dst = m1_dst;
                m2_res = m1_res;
                m1_vld = (p_cmp.dst != 5'd0);
                m1_dst = int'(p_cmp.dst);
                m1_res = ref_res(p_cmp.op, p_cmp.a, p_cmp.b);
            end
        end
    endtask

    task automatic chk(input string nm, input bit got, input bit want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, got, want, $time);
        end
    endtask

    // One clock of stimulus: advance the model past the edge, drive the new
    // inputs, and queue the outputs they should produce this cycle.
    task automatic step(input bit r, input bit s, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input logic [4:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        model_clock();
        rst         = r;
        stall       = s;
        cmp_in.op   = op;
        cmp_in.a    = a;
        cmp_in.b    = b;
        cmp_in.dst  = dst;
        rd_addr     = rd;
        p_rst       = r;
        p_stall     = s;
        p_cmp       = cmp_in;
        if (rd == 5'd0)                       e.flag = 1'b0;
        else if (m2_vld && m2_dst == int'(rd)) e.flag = m2_res;
        else                                  e.flag = m_flags[rd];
        e.busy = m1_vld && (m1_dst == int'(rd)) && (rd != 5'd0);
        sb.push_back(e);
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic [4:0] rd);
        step(1'b0, 1'b0, op, a, b, dst, rd);
    endtask

    task automatic bub(input logic [4:0] rd);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, rd);
    endtask

    task automatic stl(input logic [4:0] rd);
        step(1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0, rd);
    endtask

    task automatic direct(input string nm, input bit want_flag, input bit want_busy);
        @(negedge clk);
        chk({nm, "_flag"}, rd_flag, want_flag);
        chk({nm, "_busy"}, flag_busy, want_busy);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'h7F80_0000;
            3:       v = 32'hFF80_0000;
            4: begin
                v = 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
                v[31] = 1'($urandom_range(0, 1));
            end
            5:       v = 32'h3F80_0000;
            6:       v = 32'hBF80_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: the read port is live every cycle, so each queued entry is
    // consumed on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_rd_flag", rd_flag, e.flag);
                chk("sb_flag_busy", flag_busy, e.busy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int          drain;
        rst     = 1'b1;
        stall   = 1'b0;
        cmp_in  = '0;
        rd_addr = 5'd0;
        p_rst   = 1'b1;
        p_stall = 1'b0;
        p_cmp   = '0;
        m1_vld  = 1'b0;
        m2_vld  = 1'b0;
        m1_dst  = 0;
        m2_dst  = 0;
        m1_res  = 1'b0;
        m2_res  = 1'b0;

        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 5'd3);
        step(1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0, 5'd3);
        bub(5'd3);
        direct("reset", 1'b0, 1'b0);

        // EQ 1.0 == 1.0 into flag 3: busy, then forward, then file.
        req(2'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd3, 5'd3);
        bub(5'd3); direct("eq_t1", 1'b0, 1'b1);
        bub(5'd3); direct("eq_t2_fwd", 1'b1, 1'b0);
        bub(5'd3); direct("eq_t3_file", 1'b1, 1'b0);

        // -1.5 < 2.0, swapped, and -2.0 <= -2.0.
        req(2'd1, 32'hBFC0_0000, 32'h4000_0000, 5'd5, 5'd5);
        bub(5'd5); bub(5'd5); direct("lt_neg_pos", 1'b1, 1'b0);
        req(2'd1, 32'h4000_0000, 32'hBFC0_0000, 5'd5, 5'd5);
        bub(5'd5); bub(5'd5); direct("lt_swapped", 1'b0, 1'b0);
        req(2'd2, 32'hC000_0000, 32'hC000_0000, 5'd6, 5'd6);
        bub(5'd6); bub(5'd6); direct("le_both_neg", 1'b1, 1'b0);

        // NaN against 1.0 with every op, then -0 == +0.
        req(2'd3, 32'h7FC0_0000, 32'h3F80_0000, 5'd10, 5'd0);
        req(2'd0, 32'h7FC0_0000, 32'h3F80_0000, 5'd11, 5'd0);
        req(2'd1, 32'h7FC0_0000, 32'h3F80_0000, 5'd12, 5'd0);
        req(2'd2, 32'h7FC0_0000, 32'h3F80_0000, 5'd13, 5'd0);
        req(2'd0, 32'h8000_0000, 32'h0000_0000, 5'd14, 5'd0);
        bub(5'd0); bub(5'd0); bub(5'd0);
        bub(5'd10); direct("nan_un", 1'b1, 1'b0);
        bub(5'd11); direct("nan_eq", 1'b0, 1'b0);
        bub(5'd12); direct("nan_lt", 1'b0, 1'b0);
        bub(5'd13); direct("nan_le", 1'b0, 1'b0);
        bub(5'd14); direct("zero_eq", 1'b1, 1'b0);

        // Bubbles leave every flag alone.
        bub(5'd0); direct("flag0", 1'b0, 1'b0);
        bub(5'd0); bub(5'd0); bub(5'd0);
        bub(5'd3); direct("bubble_keep3", 1'b1, 1'b0);
        bub(5'd5); direct("bubble_keep5", 1'b0, 1'b0);

        // 1.0 < 2.0 into flag 7 held under three stall cycles.
        req(2'd1, 32'h3F80_0000, 32'h4000_0000, 5'd7, 5'd7);
        stl(5'd7); direct("stall_c1", 1'b0, 1'b1);
        stl(5'd7); direct("stall_c2", 1'b0, 1'b1);
        stl(5'd7); direct("stall_c3", 1'b0, 1'b1);
        bub(5'd7); direct("stall_drop", 1'b0, 1'b1);
        bub(5'd7); direct("stall_fwd", 1'b1, 1'b0);
        bub(5'd7); direct("stall_file", 1'b1, 1'b0);

        // Same-dst back-to-back: 1 then 0, later wins.
        req(2'd1, 32'h3F80_0000, 32'h4000_0000, 5'd7, 5'd7);
        req(2'd1, 32'h4000_0000, 32'h3F80_0000, 5'd7, 5'd7);
        bub(5'd7); direct("b2b_fwd1", 1'b1, 1'b1);
        bub(5'd7); direct("b2b_fwd0", 1'b0, 1'b0);
        bub(5'd7); direct("b2b_file", 1'b0, 1'b0);

        // Flag 9 set, then a request to 9 discarded by reset.
        req(2'd3, 32'h7FC0_0000, 32'h0000_0000, 5'd9, 5'd9);
        bub(5'd9); bub(5'd9); bub(5'd9); direct("f9_set", 1'b1, 1'b0);
        req(2'd0, 32'h0000_0000, 32'h0000_0000, 5'd9, 5'd9);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 5'd9); direct("rst_t1", 1'b1, 1'b1);
        bub(5'd9); direct("rst_after", 1'b0, 1'b0);
        bub(5'd9); direct("rst_no_write", 1'b0, 1'b0);
        bub(5'd3); direct("rst_clears3", 1'b0, 1'b0);

        // Randomized traffic, scoreboard-checked.
        for (int i = 0; i < 800; i++) begin
            ra = rand_fp();
            rb = ($urandom_range(0, 4) == 0) ? ra : rand_fp();
            step(($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)), ra, rb,
                 5'($urandom_range(0, 12)),
                 5'($urandom_range(0, 12)));
        end
        bub(5'd0);

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
